// File: rtl/fp_conv_arb.sv
// fp_conv_arb: round-robin arbiter that shares one FP format converter
// between NREQ requesters through an LAT-stage registered pipeline.
// Results return on one valid/ready port, tagged with the requester index.
// Optional macro FP_CONV_ARB_SAT_EN adds IEEE special-value handling
// (zero/subnormal flush, Inf/NaN propagation, rebias saturation).
module fp_conv_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned INX  = 8,
   parameter int unsigned INM  = 23,
   parameter int unsigned ONX  = 5,
   parameter int unsigned ONM  = 10,
   parameter int unsigned LAT  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 in_valid,
   output logic [NREQ-1:0]                 in_ready,
   input  logic [NREQ*(INX+INM+1)-1:0]     in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ONX+ONM:0]                out_data,
   output logic [$clog2(NREQ)-1:0]         out_id,
   output logic [$clog2(LAT+1):0]          inflight,
   output logic                            idle
);

   localparam int unsigned IW    = INX + INM + 1;
   localparam int unsigned OW    = ONX + ONM + 1;
   localparam int unsigned IDW   = $clog2(NREQ);
   localparam int unsigned CW    = $clog2(LAT + 1) + 1;
   localparam int unsigned MW    = (INM > ONM) ? INM : ONM;
   localparam int unsigned IBIAS = 2**(INX-1) - 1;
   localparam int unsigned OBIAS = 2**(ONX-1) - 1;
`ifdef FP_CONV_ARB_SAT_EN
   localparam int unsigned EW    = ((INX > ONX) ? INX : ONX) + 2;
`endif

   // Format conversion: sign passthrough, exponent rebias, MSB-aligned mantissa.
   function automatic logic [OW-1:0] convert(input logic [IW-1:0] op);
      logic           s;
      logic [INX-1:0] ex;
      logic [INM-1:0] mi;
      logic [ONM-1:0] mo;
`ifdef FP_CONV_ARB_SAT_EN
      logic [EW-1:0]  e;
`else
      logic [ONX-1:0] x;
`endif
      s  = op[IW-1];
      ex = op[IW-2 -: INX];
      mi = op[INM-1:0];
      // widen to MW, left-align, then keep the top ONM bits
      mo = ONM'((MW'(mi) << (MW - INM)) >> (MW - ONM));
`ifdef FP_CONV_ARB_SAT_EN
      e = EW'(ex) + EW'(OBIAS) - EW'(IBIAS);
      if (ex == '0)
         convert = {s, ONX'(0), ONM'(0)};
      else if (ex == '1)
         convert = {s, {ONX{1'b1}}, (mi != '0) ? (mo | (ONM'(1) << (ONM - 1))) : ONM'(0)};
      else if ($signed(e) >= $signed(EW'(2**ONX - 1)))
         convert = {s, {ONX{1'b1}}, ONM'(0)};
      else if ($signed(e) <= $signed(EW'(0)))
         convert = {s, ONX'(0), ONM'(0)};
      else
         convert = {s, e[ONX-1:0], mo};
`else
      // modulo-2^ONX rebias; truncating operands first gives the same low bits
      x = ONX'(ex) + ONX'(OBIAS) - ONX'(IBIAS);
      convert = {s, x, mo};
`endif
   endfunction

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gidx;
   logic [IDW-1:0]  idx;
   logic            found;
   logic [IDW-1:0]  ptr;
   logic            stall;
   logic            accept;
   logic            pop;
   logic [IW-1:0]   sel;

   logic [LAT-1:0]  vld;
   logic [OW-1:0]   dat [LAT];
   logic [IDW-1:0]  tag [LAT];

   assign out_valid = vld[LAT-1];
   assign out_data  = dat[LAT-1];
   assign out_id    = tag[LAT-1];
   assign stall     = out_valid & ~out_ready;
   assign pop       = out_valid & out_ready;
   assign accept    = found & ~stall & ~rst;
   assign sel       = in_data[32'(gidx)*IW +: IW];
   assign idle      = (inflight == '0) && (in_valid == '0);

   // Round-robin grant: first valid requester scanning upward from ptr.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      idx   = '0;
      gnt   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr) + k) % NREQ);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
      if (found)
         gnt = NREQ'(1) << gidx;
      in_ready = (stall || rst) ? '0 : gnt;
   end

   // Pipeline stages, RR pointer and occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld      <= '0;
         ptr      <= '0;
         inflight <= '0;
         for (int unsigned s = 0; s < LAT; s++) begin
            dat[s] <= '0;
            tag[s] <= '0;
         end
      end else begin
         if (!stall) begin
            vld[0] <= accept;
            dat[0] <= convert(sel);
            tag[0] <= gidx;
            for (int unsigned s = 1; s < LAT; s++) begin
               vld[s] <= vld[s-1];
               dat[s] <= dat[s-1];
               tag[s] <= tag[s-1];
            end
         end
         if (accept)
            ptr <= IDW'((32'(gidx) + 1) % NREQ);
         if (accept && !pop)
            inflight <= inflight + CW'(1);
         else if (pop && !accept)
            inflight <= inflight - CW'(1);
      end
   end

endmodule

// File: tb/tb_fp_conv_arb.sv
// tb_fp_conv_arb: directed-vector bench for fp_conv_arb with default
// parameters; expected values are hand-computed half-precision encodings.
module tb_fp_conv_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic [1:0]   out_id;
   logic [2:0]   inflight;
   logic         idle;

   int n_checks = 0;
   int n_fail   = 0;

   fp_conv_arb dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .inflight  (inflight),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic set_op(input int r, input logic [31:0] d);
      in_data[r*32 +: 32] = d;
   endtask

   // Single operation on requester r, checked two cycles after accept.
   task automatic conv(input string tag, input int r, input logic [31:0] d, input logic [15:0] want);
      @(negedge clk);
      in_valid = 4'(1 << r);
      set_op(r, d);
      #1 check({tag, "_rdy"}, 32'(in_ready), 32'(1 << r));
      @(negedge clk);
      in_valid = '0;
      @(negedge clk);
      #1;
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(want));
      check({tag, "_id"}, 32'(out_id), 32'(r));
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_rdy", 32'(in_ready), 32'd0);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_inf", 32'(inflight), 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = '0;
      #1 check("rst_idle", 32'(idle), 32'd1);

      // single op on req1, ptr 0
      @(negedge clk);
      in_valid = 4'b0010;
      set_op(1, 32'h3F80_0000);
      #1;
      check("one_rdy", 32'(in_ready), 32'b0010);
      check("one_inf0", 32'(inflight), 32'd0);
      @(negedge clk);
      in_valid = '0;
      #1;
      check("one_vld0", 32'(out_valid), 32'd0);
      check("one_inf1", 32'(inflight), 32'd1);
      @(negedge clk);
      #1;
      check("one_vld", 32'(out_valid), 32'd1);
      check("one_data", 32'(out_data), 32'h3C00);
      check("one_id", 32'(out_id), 32'd1);
      @(negedge clk);
      #1;
      check("one_vld_end", 32'(out_valid), 32'd0);
      check("one_inf_end", 32'(inflight), 32'd0);
      check("one_idle", 32'(idle), 32'd1);

      // conversion vectors; request order 2,0,1,2,3,1,3 leaves ptr at 0
      conv("neg25", 2, 32'hC020_0000, 16'hC100);
`ifdef FP_CONV_ARB_SAT_EN
      conv("big",   0, 32'h4800_0000, 16'h7C00);
      conv("tiny",  1, 32'h3580_0000, 16'h0000);
      conv("zero",  2, 32'h0000_0000, 16'h0000);
      conv("nzero", 3, 32'h8000_0000, 16'h8000);
      conv("qnan",  1, 32'h7FC0_0000, 16'h7E00);
      conv("snan",  3, 32'h7F80_0001, 16'h7E00);
`else
      conv("big",   0, 32'h4800_0000, 16'h0000);
      conv("tiny",  1, 32'h3580_0000, 16'h6C00);
      conv("zero",  2, 32'h0000_0000, 16'h4000);
      conv("nzero", 3, 32'h8000_0000, 16'hC000);
      conv("qnan",  1, 32'h7FC0_0000, 16'h3E00);
      conv("snan",  3, 32'h7F80_0001, 16'h3C00);
`endif

      // all requesters valid: grants rotate 0,1,2,3,... one result per cycle
      for (int i = 0; i < 4; i++)
         set_op(i, 32'h3F80_0000 + (32'(i) << 23));
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         in_valid = (k < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (k < 8)
            check("rr_rdy", 32'(in_ready), 32'(1 << (k % 4)));
         check("rr_inf", 32'(inflight), 32'((k < 2) ? k : ((k <= 8) ? 2 : 10 - k)));
         if (k >= 2 && k <= 9) begin
            check("rr_vld", 32'(out_valid), 32'd1);
            check("rr_id", 32'(out_id), 32'((k - 2) % 4));
            check("rr_data", 32'(out_data), 32'h3C00 + (32'((k - 2) % 4) << 10));
         end else begin
            check("rr_vld0", 32'(out_valid), 32'd0);
         end
      end

      // backpressure with two results in flight
      @(negedge clk);
      in_valid = 4'b0001;
      set_op(0, 32'h3F80_0000);
      set_op(1, 32'hC020_0000);
      #1 check("st_rdy0", 32'(in_ready), 32'b0001);
      @(negedge clk);
      in_valid = 4'b0010;
      #1 check("st_rdy1", 32'(in_ready), 32'b0010);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         in_valid  = 4'b1111;
         out_ready = 1'b0;
         #1;
         check("st_hold_rdy", 32'(in_ready), 32'd0);
         check("st_hold_vld", 32'(out_valid), 32'd1);
         check("st_hold_id", 32'(out_id), 32'd0);
         check("st_hold_data", 32'(out_data), 32'h3C00);
         check("st_hold_inf", 32'(inflight), 32'd2);
      end
      @(negedge clk);
      in_valid  = '0;
      out_ready = 1'b1;
      #1;
      check("st_out0_vld", 32'(out_valid), 32'd1);
      check("st_out0_id", 32'(out_id), 32'd0);
      check("st_out0_data", 32'(out_data), 32'h3C00);
      @(negedge clk);
      #1;
      check("st_out1_vld", 32'(out_valid), 32'd1);
      check("st_out1_id", 32'(out_id), 32'd1);
      check("st_out1_data", 32'(out_data), 32'hC100);
      check("st_out1_inf", 32'(inflight), 32'd1);
      @(negedge clk);
      #1;
      check("st_end_vld", 32'(out_valid), 32'd0);
      check("st_end_inf", 32'(inflight), 32'd0);

      // ptr is now 2: req2 alone twice, then req2 with ptr 3
      @(negedge clk);
      in_valid = 4'b0100;
      #1 check("p_rdy0", 32'(in_ready), 32'b0100);
      @(negedge clk);
      #1 check("p_rdy1", 32'(in_ready), 32'b0100);
      @(negedge clk);
      in_valid = 4'b1001;
      #1;
      check("p_rdy_ptr3", 32'(in_ready), 32'b1000);
      check("p_id0", 32'(out_id), 32'd2);
      @(negedge clk);
      in_valid = '0;
      #1;
      check("p_id1", 32'(out_id), 32'd2);
      check("p_inf_both", 32'(inflight), 32'd2);
      @(negedge clk);
      #1 check("p_id2", 32'(out_id), 32'd3);
      @(negedge clk);
      #1;
      check("p_end_vld", 32'(out_valid), 32'd0);
      check("p_end_inf", 32'(inflight), 32'd0);

      // reset with two operations in flight
      @(negedge clk);
      in_valid = 4'b0010;
      #1 check("r_rdy0", 32'(in_ready), 32'b0010);
      @(negedge clk);
      in_valid = 4'b0100;
      #1 check("r_rdy1", 32'(in_ready), 32'b0100);
      @(negedge clk);
      in_valid = 4'b1111;
      rst      = 1'b1;
      #1;
      check("r_rdy_rst", 32'(in_ready), 32'd0);
      check("r_inf_pre", 32'(inflight), 32'd2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("r_vld", 32'(out_valid), 32'd0);
      check("r_inf", 32'(inflight), 32'd0);
      check("r_ptr0", 32'(in_ready), 32'b0001);
      @(negedge clk);
      in_valid = '0;
      #1;
      check("r_stale", 32'(out_valid), 32'd0);
      check("r_inf1", 32'(inflight), 32'd1);
      @(negedge clk);
      #1;
      check("r_new_vld", 32'(out_valid), 32'd1);
      check("r_new_id", 32'(out_id), 32'd0);
      check("r_new_data", 32'(out_data), 32'h3C00);
      @(negedge clk);
      #1;
      check("r_end_vld", 32'(out_valid), 32'd0);
      check("r_end_inf", 32'(inflight), 32'd0);
      check("r_end_idle", 32'(idle), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
